// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam int unsigned REG_ZERO            = 0;
  localparam int unsigned DEFAULT_MEM_TIMEOUT = 15;
  localparam int unsigned TIMER_W             = 8;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts data-memory wait cycles; expired_c flags that the count reached MEM_TIMEOUT.
module mem_wait_timer
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic inc,
  input  logic clear,
  output logic expired_c
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= TIMER_W'(1);
    end else if (inc) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign expired_c = (count == TIMER_W'(MEM_TIMEOUT));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline (load-use, branch/jump, memory wait).
// Build option: define HAZARD_PERF_CNT_EN to implement the stall/flush performance counters.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 6,
  parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_write_register,
  input  logic                  ex_branch_taken,
  input  logic                  id_jump,
  input  logic                  mem_mem_read,
  input  logic                  mem_mem_write,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_hold,
  output logic                  id_ex_flush,
  output logic                  ex_mem_hold,
  output logic                  mem_wb_bubble,
  output logic                  mem_error,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  state_e state, state_nxt;
  logic   mem_access, load_use;
  logic   freeze, run_rules;
  logic   timer_load, timer_inc, timer_clear, timer_expired;

  assign mem_access = mem_mem_read | mem_mem_write;
  assign load_use   = ex_mem_read
                    && (ex_write_register != REG_ADDR_W'(REG_ZERO))
                    && ((ex_write_register == id_rs) || (ex_write_register == id_rt));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .inc       (timer_inc),
    .clear     (timer_clear),
    .expired_c (timer_expired)
  );

  // Next state and control outputs; while reset is high every output keeps its reset value.
  always_comb begin
    state_nxt     = state;
    mem_req       = 1'b0;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_hold    = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_hold   = 1'b0;
    mem_wb_bubble = 1'b0;
    mem_error     = 1'b0;
    timer_load    = 1'b0;
    timer_inc     = 1'b0;
    timer_clear   = 1'b0;
    freeze        = 1'b0;
    run_rules     = 1'b0;

    if (!reset) begin
      unique case (state)
        RUN: begin
          mem_req = mem_access;
          if (mem_access && !mem_ready) begin
            freeze     = 1'b1;
            timer_load = 1'b1;
            state_nxt  = MEM_WAIT;
          end else begin
            run_rules = 1'b1;
          end
        end
        MEM_WAIT: begin
          mem_req = mem_access;
          if (mem_ready) begin
            run_rules   = 1'b1;
            timer_clear = 1'b1;
            state_nxt   = RUN;
          end else begin
            freeze = 1'b1;
            if (timer_expired) begin
              state_nxt = ERROR;
            end else begin
              timer_inc = 1'b1;
            end
          end
        end
        ERROR: begin
          freeze    = 1'b1;
          mem_error = 1'b1;
        end
        default: state_nxt = RUN;
      endcase

      if (freeze) begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_hold    = 1'b1;
        ex_mem_hold   = 1'b1;
        mem_wb_bubble = 1'b1;
      end

      // A taken branch squashes the instructions that would cause load-use or jump.
      if (run_rules) begin
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end else if (id_jump) begin
          if_id_flush = 1'b1;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if ((if_id_flush || id_ex_flush) && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
